// File: rtl/cpu_pc_stack.sv
// Program counter with a return-address stack for call/ret.
// One command per edge, priority load > call > ret > inc; err is a sticky over/underflow flag.
module cpu_pc_stack #(
    parameter int N     = 8,
    parameter int DEPTH = 4,
    localparam int SPW  = $clog2(DEPTH + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   d,
    input  logic           load,
    input  logic           inc,
    input  logic           call,
    input  logic           ret,
    input  logic           clr_err,
    output logic [N-1:0]   q,
    output logic [SPW-1:0] sp,
    output logic           full,
    output logic           empty,
    output logic           err
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [N-1:0]   r_q;
    logic [SPW-1:0] r_sp;
    logic           r_err;
    logic [N-1:0]   r_stack [0:DEPTH-1];

    logic [N-1:0]   w_q_next;
    logic [SPW-1:0] w_sp_next;
    logic           w_err_set;
    logic           w_push;
    logic [SPW-1:0] w_top;
    logic [N-1:0]   w_ret_addr;
    logic           w_full;
    logic           w_empty;

    assign w_full     = (r_sp == SPW'(DEPTH));
    assign w_empty    = (r_sp == '0);
    assign w_top      = r_sp - SPW'(1);
    assign w_ret_addr = r_q + N'(1);

    always_comb begin
        w_q_next  = r_q;
        w_sp_next = r_sp;
        w_err_set = 1'b0;
        w_push    = 1'b0;
        if (load) begin
            w_q_next = d;
        end else if (call) begin
            if (w_full) begin
                w_err_set = 1'b1;
            end else begin
                w_push    = 1'b1;
                w_sp_next = r_sp + SPW'(1);
                w_q_next  = d;
            end
        end else if (ret) begin
            if (w_empty) begin
                w_err_set = 1'b1;
            end else begin
                w_sp_next = w_top;
                w_q_next  = r_stack[w_top[IW-1:0]];
            end
        end else if (inc) begin
            w_q_next = r_q + N'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q   <= '0;
            r_sp  <= '0;
            r_err <= 1'b0;
        end else begin
            r_q   <= w_q_next;
            r_sp  <= w_sp_next;
            // a new over/underflow wins over a same-cycle clear
            r_err <= w_err_set | (r_err & ~clr_err);
        end
    end

    // Storage is left unreset; entries at or above sp are never read.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_stack[r_sp[IW-1:0]] <= w_ret_addr;
        end
    end

    assign q     = r_q;
    assign sp    = r_sp;
    assign err   = r_err;
    assign full  = w_full;
    assign empty = w_empty;

endmodule

// File: tb/tb_cpu_pc_stack.sv
// Scoreboard bench for cpu_pc_stack: stimulus queues expected state, a monitor pops and compares.
module tb_cpu_pc_stack;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d;
    logic       load, inc, call, ret, clr_err;
    logic [7:0] q;
    logic [2:0] sp;
    logic       full, empty, err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] q;
        logic [2:0] sp;
        logic       err;
        string      nm;
    } exp_t;

    exp_t sb[$];
    event async_ev;

    cpu_pc_stack #(.N(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .d(d), .load(load), .inc(inc), .call(call),
        .ret(ret), .clr_err(clr_err), .q(q), .sp(sp), .full(full),
        .empty(empty), .err(err)
    );

    always #5 clk = ~clk;

    function automatic void cmp(input string nm, input string fld, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s.%s actual=%0h expected=%0h", nm, fld, act, expv);
        end
    endfunction

    // Monitor: wakes after every clock edge or an async-reset probe and checks one entry.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or async_ev);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                cmp(e.nm, "q",     int'(q),     int'(e.q));
                cmp(e.nm, "sp",    int'(sp),    int'(e.sp));
                cmp(e.nm, "err",   int'(err),   int'(e.err));
                cmp(e.nm, "full",  int'(full),  int'(e.sp == 3'd4));
                cmp(e.nm, "empty", int'(empty), int'(e.sp == 3'd0));
            end
        end
    end

    task automatic step(input logic l, input logic c, input logic r, input logic i,
                        input logic cl, input logic [7:0] dd,
                        input logic [7:0] eq, input logic [2:0] esp, input logic eerr,
                        input string nm);
        exp_t e;
        @(negedge clk);
        load = l; call = c; ret = r; inc = i; clr_err = cl; d = dd;
        e.q = eq; e.sp = esp; e.err = eerr; e.nm = nm;
        sb.push_back(e);
        @(posedge clk);
        #2;
        load = 0; call = 0; ret = 0; inc = 0; clr_err = 0;
    endtask

    task automatic probe(input logic [7:0] eq, input logic [2:0] esp, input logic eerr,
                         input string nm);
        exp_t e;
        e.q = eq; e.sp = esp; e.err = eerr; e.nm = nm;
        sb.push_back(e);
        -> async_ev;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; d = '0; load = 0; inc = 0; call = 0; ret = 0; clr_err = 0;
        #2 probe(8'h00, 3'd0, 1'b0, "reset");
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        //    l c r i cl  d       q      sp    err
        step(0,0,0,1,0, 8'h00, 8'h01, 3'd0, 1'b0, "inc1");
        step(0,0,0,1,0, 8'h00, 8'h02, 3'd0, 1'b0, "inc2");
        step(0,0,0,1,0, 8'h00, 8'h03, 3'd0, 1'b0, "inc3");
        step(1,0,0,0,0, 8'hFF, 8'hFF, 3'd0, 1'b0, "loadFF");
        step(0,0,0,1,0, 8'h00, 8'h00, 3'd0, 1'b0, "wrap");

        step(1,0,0,0,0, 8'h10, 8'h10, 3'd0, 1'b0, "load10");
        step(0,1,0,0,0, 8'h40, 8'h40, 3'd1, 1'b0, "call40");
        step(0,1,0,0,0, 8'h80, 8'h80, 3'd2, 1'b0, "call80");
        step(0,0,1,0,0, 8'h00, 8'h41, 3'd1, 1'b0, "ret41");
        step(0,0,1,0,0, 8'h00, 8'h11, 3'd0, 1'b0, "ret11");

        step(1,0,0,0,0, 8'h22, 8'h22, 3'd0, 1'b0, "load22");
        step(0,0,1,0,0, 8'h00, 8'h22, 3'd0, 1'b1, "underflow");
        step(0,0,1,0,1, 8'h00, 8'h22, 3'd0, 1'b1, "uflow_clr");
        step(0,0,0,0,1, 8'h00, 8'h22, 3'd0, 1'b0, "clr1");

        step(0,1,0,0,0, 8'h31, 8'h31, 3'd1, 1'b0, "callA");
        step(0,1,0,0,0, 8'h32, 8'h32, 3'd2, 1'b0, "callB");
        step(0,1,0,0,0, 8'h33, 8'h33, 3'd3, 1'b0, "callC");
        step(0,1,0,0,0, 8'h34, 8'h34, 3'd4, 1'b0, "callD");
        step(0,1,0,0,0, 8'h35, 8'h34, 3'd4, 1'b1, "overflow");
        step(0,0,0,0,1, 8'h00, 8'h34, 3'd4, 1'b0, "clr2");
        step(0,0,0,0,0, 8'h99, 8'h34, 3'd4, 1'b0, "idle");
        step(0,0,1,0,0, 8'h00, 8'h34, 3'd3, 1'b0, "retD");
        step(0,0,1,0,0, 8'h00, 8'h33, 3'd2, 1'b0, "retC");
        step(0,0,1,0,0, 8'h00, 8'h32, 3'd1, 1'b0, "retB");
        step(0,0,1,0,0, 8'h00, 8'h23, 3'd0, 1'b0, "retA");

        step(1,1,1,1,0, 8'h55, 8'h55, 3'd0, 1'b0, "all4");
        step(0,1,0,0,0, 8'h60, 8'h60, 3'd1, 1'b0, "call60");
        step(0,1,1,0,0, 8'h70, 8'h70, 3'd2, 1'b0, "call_ret");
        step(0,0,1,0,0, 8'h00, 8'h61, 3'd1, 1'b0, "ret61");
        step(0,0,1,0,0, 8'h00, 8'h56, 3'd0, 1'b0, "ret56");
        step(0,0,1,1,0, 8'h00, 8'h56, 3'd0, 1'b1, "ret_inc_uflow");
        step(0,0,0,0,1, 8'h00, 8'h56, 3'd0, 1'b0, "clr3");

        step(1,0,0,0,0, 8'h2E, 8'h2E, 3'd0, 1'b0, "load2E");
        step(0,1,0,0,0, 8'h50, 8'h50, 3'd1, 1'b0, "call50");
        step(0,1,0,0,0, 8'h30, 8'h30, 3'd2, 1'b0, "call30");
        #1 rst = 1'b1;
        #1 probe(8'h00, 3'd0, 1'b0, "async_rst");
        step(0,1,0,0,0, 8'h99, 8'h00, 3'd0, 1'b0, "call_in_rst");
        @(negedge clk);
        rst = 1'b0;
        step(0,0,1,0,0, 8'h00, 8'h00, 3'd0, 1'b1, "ret_after_rst");

        @(posedge clk); #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
